dot_accum: RTL and testbench

//  Streaming signed multiply-accumulate back end. It consumes the 2*WIDTH-bit two's-complement products
//  of the array multiplier, one per beat, and sums each vector (terminated by in_last_i).
//  It then rounds and saturates the sum to an OUT_WIDTH fixed-point result.

---
 rtl/gpu_fixed_pkg.sv | 29 ++
 rtl/fixed_round_sat.sv | 31 +++
 rtl/dot_accum.sv | 115 +++++++++++
 tb/tb_dot_accum.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/gpu_fixed_pkg.sv
// Shared fixed-point helpers for the GPU output stages: rounding, saturation bounds, accumulator type.
package gpu_fixed_pkg;

  localparam int unsigned DEF_ACC_WIDTH = 32;
  localparam int unsigned DEF_FRAC_BITS = 8;
  localparam int unsigned ROUND_HALF    = 1 << (DEF_FRAC_BITS - 1);

  typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;

  // Round half up then arithmetic shift right by frac bits; frac = 0 passes through.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int unsigned frac);
    logic signed [63:0] r;
    r = v;
    if (frac != 0) r = (v + (64'sd1 <<< (frac - 1))) >>> frac;
    return r;
  endfunction

  // Largest value representable in a signed field of width w.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational round-and-clamp of a signed accumulator into a narrower signed result.
module fixed_round_sat #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 sat
);
  import gpu_fixed_pkg::*;

  logic signed [63:0] wide;
  logic signed [63:0] shifted;

  // Widen, round, then clamp to the output range and flag any clamping.
  always_comb begin
    wide    = 64'($signed(acc));
    shifted = round_shift(wide, FRAC_BITS);
    sat     = 1'b0;
    data    = OUT_WIDTH'(shifted);
    if (shifted > sat_max(OUT_WIDTH)) begin
      data = OUT_WIDTH'(sat_max(OUT_WIDTH));
      sat  = 1'b1;
    end else if (shifted < sat_min(OUT_WIDTH)) begin
      data = OUT_WIDTH'(sat_min(OUT_WIDTH));
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/dot_accum.sv
// Streaming signed multiply-accumulate back end: sums product vectors, rounds and saturates the result.
module dot_accum #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*WIDTH-1:0]   in_prod_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_sat_o,
  output logic [CNT_WIDTH-1:0] out_count_o
);
  import gpu_fixed_pkg::*;

  logic                 s1_valid;
  logic                 s1_last;
  logic [ACC_WIDTH-1:0] s1_prod;
  logic                 s1_advance;
  logic                 accept;
  logic                 load;

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic                 first;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_inc;

  logic [OUT_WIDTH-1:0] rs_data;
  logic                 rs_sat;

  // Handshake: S1 stalls only when a last beat cannot drop into a full, unconsumed result register.
  always_comb begin
    s1_advance = s1_valid & ~(s1_last & out_valid_o & ~out_ready_i);
    in_ready_o = ~clear_i & (~s1_valid | s1_advance);
    accept     = in_valid_i & in_ready_o;
    load       = s1_advance & s1_last & ~clear_i;
    sum        = (first ? '0 : acc) + s1_prod;
    count_inc  = (&count) ? count : count + CNT_WIDTH'(1);
  end

  // S1: register the accepted beat with its product sign-extended to the accumulator width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (clear_i) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_last  <= in_last_i;
      s1_prod  <= ACC_WIDTH'($signed(in_prod_i));
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: accumulate the partial sum and count terms; a last beat restarts the next vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      first <= 1'b1;
      count <= '0;
    end else if (clear_i) begin
      first <= 1'b1;
      count <= '0;
    end else if (s1_advance) begin
      acc <= sum;
      if (s1_last) begin
        first <= 1'b1;
        count <= '0;
      end else begin
        first <= 1'b0;
        count <= count_inc;
      end
    end
  end

  fixed_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .acc  (sum),
    .data (rs_data),
    .sat  (rs_sat)
  );

  // Result register: reload takes priority over consume so back-to-back results have no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_sat_o   <= 1'b0;
      out_count_o <= '0;
    end else if (load) begin
      out_valid_o <= 1'b1;
      out_data_o  <= rs_data;
      out_sat_o   <= rs_sat;
      out_count_o <= count_inc;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Directed bench for dot_accum with hand-computed expected results.
module tb_dot_accum;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_prod_i;
  logic        in_last_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic        out_sat_o;
  logic [9:0]  out_count_o;

  int errors = 0;
  int checks = 0;
  int waited;

  dot_accum dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_prod_i   (in_prod_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_sat_o   (out_sat_o),
    .out_count_o (out_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat from a negedge and hold it until accepted on a rising edge.
  task automatic send_beat(input logic [15:0] prod, input logic last);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid_i = 1'b1;
    in_prod_i  = prod;
    in_last_i  = last;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (in_ready_o) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  // Called at a negedge: wait for a result, check it, then step past the consuming edge.
  task automatic expect_result(input string tag, input logic [15:0] data,
                               input logic [9:0] cnt, input logic sat, output int nwait);
    nwait = 0;
    while (!out_valid_o && nwait < 200) begin
      @(negedge clk);
      nwait++;
    end
    check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    check({tag, "_data"},  32'(out_data_o),  32'(data));
    check({tag, "_count"}, 32'(out_count_o), 32'(cnt));
    check({tag, "_sat"},   32'(out_sat_o),   32'(sat));
    @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    clear_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_prod_i   = '0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_data",  32'(out_data_o),  32'd0);
    check("rst_sat",   32'(out_sat_o),   32'd0);
    check("rst_count", 32'(out_count_o), 32'd0);
    check("rst_ready", 32'(in_ready_o),  32'd1);

    // Test 1: 1+2+3 and the two-edge latency
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0200, 1'b0);
    send_beat(16'h0300, 1'b1);
    @(negedge clk);
    check("t1_early", 32'(out_valid_o), 32'd0);
    expect_result("t1", 16'd6, 10'd3, 1'b0, waited);
    check("t1_lat", 32'(waited), 32'd1);

    // Test 2: rounding of negative halves
    send_beat(16'hFE80, 1'b1);
    @(negedge clk);
    expect_result("t2a", 16'hFFFF, 10'd1, 1'b0, waited);
    send_beat(16'hFE7F, 1'b1);
    @(negedge clk);
    expect_result("t2b", 16'hFFFE, 10'd1, 1'b0, waited);

    // Test 3: positive saturation over 512 terms
    for (int i = 0; i < 512; i++) send_beat(16'h4000, i == 511);
    @(negedge clk);
    expect_result("t3", 16'h7FFF, 10'd512, 1'b1, waited);

    // Negative saturation: 257 * -32768 = -8421376 -> -32896 clamps to min
    for (int i = 0; i < 257; i++) send_beat(16'h8000, i == 256);
    @(negedge clk);
    expect_result("tneg", 16'h8000, 10'd257, 1'b1, waited);

    // Term count saturates at all-ones
    for (int i = 0; i < 1100; i++) send_beat(16'h0000, i == 1099);
    @(negedge clk);
    expect_result("tcnt", 16'h0000, 10'h3FF, 1'b0, waited);

    // Test 4: backpressure, B's last parks in S1, then in-order drain with no bubble
    @(negedge clk);
    out_ready_i = 1'b0;
    send_beat(16'h0100, 1'b1);
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0100, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_stall_ready", 32'(in_ready_o),  32'd0);
    check("t4_hold_valid",  32'(out_valid_o), 32'd1);
    check("t4_hold_data",   32'(out_data_o),  32'd1);
    out_ready_i = 1'b1;
    expect_result("t4a", 16'd1, 10'd1, 1'b0, waited);
    expect_result("t4b", 16'd2, 10'd2, 1'b0, waited);
    check("t4_no_bubble", 32'(waited), 32'd0);
    check("t4_drained", 32'(out_valid_o), 32'd0);

    // Test 5: clear drops the partial vector
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0100, 1'b0);
    @(negedge clk);
    clear_i = 1'b1;
    #1;
    check("t5_clear_ready", 32'(in_ready_o), 32'd0);
    @(negedge clk);
    clear_i = 1'b0;
    send_beat(16'h0100, 1'b1);
    @(negedge clk);
    expect_result("t5", 16'd1, 10'd1, 1'b0, waited);

    // Test 6: reset mid-vector with a result pending
    out_ready_i = 1'b0;
    send_beat(16'h0300, 1'b1);
    send_beat(16'h0100, 1'b0);
    @(negedge clk);
    check("t6_pending", 32'(out_valid_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid_o), 32'd0);
    check("t6_rst_count", 32'(out_count_o), 32'd0);
    @(negedge clk);
    reset_n     = 1'b1;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_stale", 32'(out_valid_o), 32'd0);
    send_beat(16'h0200, 1'b1);
    @(negedge clk);
    expect_result("t6", 16'd2, 10'd1, 1'b0, waited);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
